// File: rtl/onehot_grant_pkg.sv
// Shared types and constants for the one-hot grant decoder slice.
package onehot_grant_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_IDXW    = 2;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counter width able to hold 0..timeout; never narrower than one bit.
  function automatic int timer_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/onehot_grant_decoder_timer.sv
// Saturating hold timer: cleared outside a grant, counts while a grant is
// live, and flags the cycle on which the grant must be forcibly released.
module grant_timer
  import onehot_grant_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = timer_w(TIMEOUT);

  logic [TW-1:0] count;

  // Count up while enabled, stick at all-ones, restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_expiry
      // The last allowed hold cycle is the one where count reaches TIMEOUT-1.
      localparam logic [TW-1:0] EXP_AT = TW'(TIMEOUT - 1);
      assign expired = en && (count == EXP_AT);
    end else begin : g_no_expiry
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/onehot_grant_decoder.sv
// Expands an encoded requester index into a registered one-hot grant, holds
// it until the granted requester acks or the hold timer expires, then forces
// one dead cycle before the next index can be accepted.
module onehot_grant_decoder
  import onehot_grant_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int IDXW    = DEF_IDXW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] idx_in,
  input  logic            idx_valid,
  output logic            idx_ready,
  input  logic [N-1:0]    ack,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic            timeout_err,
  output logic            busy
);

  localparam bit IDX_FULL = (N == (1 << IDXW));

  state_t        state;
  state_t        state_nxt;
  logic          idx_ok;
  logic          accept;
  logic          ack_hit;
  logic          expired;
  logic          release_now;
  logic [N-1:0]  onehot;

  // Only indices that name a real requester are accepted; when the index
  // space is exactly N wide every code is legal.
  generate
    if (IDX_FULL) begin : g_idx_full
      assign idx_ok = 1'b1;
    end else begin : g_idx_range
      assign idx_ok = (32'(idx_in) < 32'(N));
    end
  endgenerate

  assign onehot      = {{(N-1){1'b0}}, 1'b1} << idx_in;
  assign accept      = idx_valid && idx_ready && idx_ok;
  assign ack_hit     = |(ack & grant);
  assign release_now = (state == GRANT) && (ack_hit || expired);
  assign grant_valid = |grant;

  grant_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != GRANT),
    .en      (state == GRANT),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept -> hold -> one dead cycle -> back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = RELEASE;
      RELEASE:                  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Moore handshake outputs.
  always_comb begin
    idx_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // One-hot grant register; async reset drops a live grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
    end else if (accept) begin
      grant <= onehot;
    end else if (release_now) begin
      grant <= '0;
    end
  end

  // Forced-release pulse; a matching ack on the expiry cycle suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == GRANT) && expired && !ack_hit;
    end
  end

endmodule

// File: doc/onehot_grant_decoder.md
Name: onehot_grant_decoder

Overview:
Reverse direction of the team's 4-to-2 priority encoder. Accepts an encoded index plus its valid/enable flag and expands it to a registered one-hot grant. Holds the grant until the selected requester acknowledges or a timeout expires. Sits between the request priority encoder and the requester bank, closing the request/grant loop with break-before-make sequencing.

Parameters:
- N, 4, number of requesters (one-hot grant width).
- IDXW, 2, encoded index width; must equal clog2(N).
- TIMEOUT, 15, max cycles a grant is held without ack before forced release; 0 disables the timeout.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- idx_in  input  IDXW  encoded requester index (encoder output {a,b}).
- idx_valid  input  1  index valid (encoder en).
- idx_ready  output  1  block can accept an index.
- ack  input  N  per-requester release/done strobe.
- grant  output  N  registered one-hot grant.
- grant_valid  output  1  high while grant is non-zero.
- timeout_err  output  1  one-cycle pulse on forced release.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (asserted asynchronously, mid-operation included):
  - grant=0, grant_valid=0, timeout_err=0, busy=0, idx_ready=1.
  - State=IDLE, timer=0.
  - Any live grant drops immediately, without waiting for a clock edge.
- FSM states: IDLE, GRANT, RELEASE. Moore outputs: idx_ready=(state==IDLE), busy=(state!=IDLE).
- IDLE:
  - Accept when idx_valid && idx_ready && idx_in<N. Next edge: grant=1<<idx_in, grant_valid=1, timer=0, state=GRANT. Latency: 1 cycle from accept to grant.
  - idx_in>=N (only possible when N is not a power of 2): no capture, stay IDLE.
  - idx_valid low: stay IDLE, grant=0.
- GRANT:
  - idx_in/idx_valid are ignored; grant is stable.
  - timer increments by 1 each cycle, saturating.
  - ack bit matching the granted index =1: next edge grant=0, grant_valid=0, state=RELEASE. ack bits on non-granted positions are ignored.
  - TIMEOUT>0, timer==TIMEOUT-1 and no matching ack: next edge grant=0, timeout_err=1 for exactly one cycle, state=RELEASE.
  - Matching ack in the same cycle as timeout expiry: ack wins; no timeout_err.
- RELEASE:
  - One dead cycle: grant=0, idx_ready=0. Next edge goes to IDLE.
  - Guarantees at least one zero-grant cycle between consecutive grants.
- Minimum turnaround: accept at cycle t, grant at t+1, ack at t+1, grant low at t+2, ready at t+3, next grant at t+4.
- Invariants: grant is always zero or one-hot; grant_valid==|grant.
- Widths: timer width = clog2(TIMEOUT+1), minimum 1. Shifting 1<<idx_in is done at width N.

Decomposition:
- Shared package onehot_grant_pkg:
  - State enum (IDLE, GRANT, RELEASE).
  - Default N, IDXW, TIMEOUT constants.
  - Timer-width function.
- Sub-module grant_timer:
  - Clear/enable saturating counter with expiry flag. Async active-low reset; expiry tied low when TIMEOUT=0.
- FSM and one-hot register stay in the top module.

Test Plan:
- Reset check: assert rst_n=0 while grant=4'b0100 -> grant drops to 0 immediately (no edge). After release: idx_ready=1, busy=0, timeout_err=0.
- Basic decode: idx_in=2'b11, idx_valid=1 for one cycle -> next cycle grant=4'b1000, grant_valid=1, idx_ready=0. ack=4'b1000 -> grant=0 next cycle, one RELEASE cycle, then idx_ready=1.
- Wrong ack: grant=4'b0010, drive ack=4'b0101 for 5 cycles -> grant held at 4'b0010. ack=4'b0010 -> release.
- Timeout: TIMEOUT=15, grant=4'b0001, no ack -> grant held exactly 15 cycles, then grant=0 with timeout_err high for exactly 1 cycle.
- Ack/timeout collision: matching ack on the expiry cycle -> release with timeout_err=0.
- Back-to-back: idx_valid held high with idx_in=0 then 1 -> grants 4'b0001 and 4'b0010 separated by at least one zero-grant cycle. Accept spacing is 3 cycles when ack is immediate. grant is never non-one-hot (assertion).
